fp_addsub_pipe: RTL and testbench

//  Pipelined, parametrised IEEE-754 binary add/subtract unit for the FP ALU datapath (default binary32).

---
 rtl/fp_pkg.sv | 30 +++
 rtl/fp_lzc.sv | 20 ++
 rtl/fp_addsub_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared defaults and bit-pattern helpers for the IEEE-754 add/sub unit (binary32 by default).
package fp_pkg;

    localparam int unsigned DEF_EXP_W   = 8;
    localparam int unsigned DEF_FRAC_W  = 23;
    localparam int unsigned DEF_W       = 1 + DEF_EXP_W + DEF_FRAC_W;
    localparam int unsigned DEF_BIAS    = (1 << (DEF_EXP_W - 1)) - 1;
    localparam int unsigned DEF_EXP_MAX = (1 << DEF_EXP_W) - 1;
    localparam int unsigned DEF_MANT_W  = DEF_FRAC_W + 4;

    // Unpacked operand: hidden bit + fraction + guard/round/sticky.
    typedef struct packed {
        logic                  sign;
        logic [DEF_EXP_W-1:0]  exp;
        logic [DEF_MANT_W-1:0] mant;
    } unpacked_t;

    function automatic logic [DEF_W-1:0] qnan_pat();
        return {1'b0, {DEF_EXP_W{1'b1}}, 1'b1, {(DEF_FRAC_W - 1){1'b0}}};
    endfunction

    function automatic logic [DEF_W-1:0] inf_pat(input logic sign);
        return {sign, {DEF_EXP_W{1'b1}}, {DEF_FRAC_W{1'b0}}};
    endfunction

    function automatic logic [DEF_W-1:0] zero_pat(input logic sign);
        return {sign, {(DEF_W - 1){1'b0}}};
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input reports IN_W.
module fp_lzc #(
    parameter  int unsigned IN_W  = 27,
    localparam int unsigned CNT_W = $clog2(IN_W + 1)
) (
    input  logic [IN_W-1:0]  in_vec,
    output logic [CNT_W-1:0] count_c
);

    // Highest set bit wins because it is visited last.
    always_comb begin
        count_c = CNT_W'(IN_W);
        for (int i = 0; i < int'(IN_W); i++) begin
            if (in_vec[i]) begin
                count_c = CNT_W'(int'(IN_W) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754 add/subtract with RNE rounding, FTZ and overflow/underflow flags.
// Define FP_ADDSUB_SPECIAL_EN to decode all-ones exponents as inf/NaN.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter  int unsigned EXP_W  = DEF_EXP_W,
    parameter  int unsigned FRAC_W = DEF_FRAC_W,
    localparam int unsigned W      = 1 + EXP_W + FRAC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op_sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         overflow,
    output logic         underflow
);

    localparam int unsigned MW       = FRAC_W + 4;
    localparam int unsigned EW       = EXP_W + 2;
    localparam int unsigned CW       = $clog2(MW + 1);
    localparam int unsigned EXP_ONES = (1 << EXP_W) - 1;

    logic advance;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // ---------------- S1: unpack, order by magnitude, align ----------------
    logic              sa, sb, a_zero, b_zero, swap, sx;
    logic [EXP_W-1:0]  ea, eb, ex, ey, diff;
    logic [FRAC_W-1:0] fa, fb, fx, fy;
    logic [MW-1:0]     mx, my_full, my, mask;
    logic              byp_c;
    logic [W-1:0]      byp_val_c;
`ifdef FP_ADDSUB_SPECIAL_EN
    logic              a_inf, b_inf, a_nan, b_nan;
`endif

    always_comb begin
        sa      = a[W-1];
        ea      = a[W-2:FRAC_W];
        fa      = a[FRAC_W-1:0];
        sb      = b[W-1] ^ op_sub;
        eb      = b[W-2:FRAC_W];
        fb      = b[FRAC_W-1:0];
        a_zero  = (ea == '0);
        b_zero  = (eb == '0);
        swap    = {eb, fb} > {ea, fa};
        sx      = swap ? sb : sa;
        ex      = swap ? eb : ea;
        fx      = swap ? fb : fa;
        ey      = swap ? ea : eb;
        fy      = swap ? fa : fb;
        diff    = ex - ey;
        mx      = {1'b1, fx, 3'b000};
        my_full = {1'b1, fy, 3'b000};
        mask    = ~({MW{1'b1}} << diff);
        // Past the sticky position only the (always nonzero) sticky survives.
        if (diff >= EXP_W'(MW - 1)) begin
            my = {{(MW - 1){1'b0}}, 1'b1};
        end else begin
            my = (my_full >> diff) | {{(MW - 1){1'b0}}, |(my_full & mask)};
        end

        byp_c     = 1'b0;
        byp_val_c = '0;
        if (a_zero && b_zero) begin
            byp_c     = 1'b1;
            byp_val_c = {sa & sb, {(W - 1){1'b0}}};
        end else if (a_zero) begin
            byp_c     = 1'b1;
            byp_val_c = {sb, b[W-2:0]};
        end else if (b_zero) begin
            byp_c     = 1'b1;
            byp_val_c = a;
        end
`ifdef FP_ADDSUB_SPECIAL_EN
        a_inf = (ea == '1) && (fa == '0);
        b_inf = (eb == '1) && (fb == '0);
        a_nan = (ea == '1) && (fa != '0);
        b_nan = (eb == '1) && (fb != '0);
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            byp_c     = 1'b1;
            byp_val_c = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W - 1){1'b0}}};
        end else if (a_inf) begin
            byp_c     = 1'b1;
            byp_val_c = {sa, ea, fa};
        end else if (b_inf) begin
            byp_c     = 1'b1;
            byp_val_c = {sb, eb, fb};
        end
`endif
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic              v1, v2;
    logic              s1_sign, s1_sub, s1_byp;
    logic [EXP_W-1:0]  s1_exp;
    logic [MW-1:0]     s1_mx, s1_my;
    logic [W-1:0]      s1_byp_val;
    logic              s2_sign, s2_byp;
    logic [EXP_W-1:0]  s2_exp;
    logic [MW:0]       s2_sum;
    logic [W-1:0]      s2_byp_val;

    logic [CW-1:0]     lz_c;
    logic [MW-1:0]     norm;
    logic [EW-1:0]     e_norm, e_fin;
    logic              up;
    logic [FRAC_W+1:0] mant_r;
    logic [FRAC_W-1:0] frac_r;
    logic [W-1:0]      res_c;
    logic              ovf_c, unf_c;

    fp_lzc #(.IN_W(MW)) u_lzc (
        .in_vec  (s2_sum[MW-1:0]),
        .count_c (lz_c)
    );

    always_comb begin
        res_c = '0;
        ovf_c = 1'b0;
        unf_c = 1'b0;
        if (s2_sum[MW]) begin
            norm   = {s2_sum[MW:2], |s2_sum[1:0]};
            e_norm = EW'(s2_exp) + EW'(1);
        end else begin
            norm   = s2_sum[MW-1:0] << lz_c;
            e_norm = EW'(s2_exp) - EW'(lz_c);
        end
        up     = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r = {1'b0, norm[MW-1:3]} + (FRAC_W + 2)'(up);
        e_fin  = e_norm + EW'(mant_r[FRAC_W+1]);
        frac_r = mant_r[FRAC_W+1] ? mant_r[FRAC_W:1] : mant_r[FRAC_W-1:0];

        if (s2_byp) begin
            res_c = s2_byp_val;
        end else if (s2_sum == '0) begin
            res_c = '0;
        end else if (!e_fin[EW-1] && (e_fin >= EW'(EXP_ONES))) begin
            res_c = {s2_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            ovf_c = 1'b1;
        end else if (e_fin[EW-1] || (e_fin == '0)) begin
            res_c = {s2_sign, {(W - 1){1'b0}}};
            unf_c = 1'b1;
        end else begin
            res_c = {s2_sign, e_fin[EXP_W-1:0], frac_r};
        end
    end

    // All stages advance together; S2 add/sub is folded into its register load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1         <= 1'b0;
            s1_sign    <= 1'b0;
            s1_sub     <= 1'b0;
            s1_byp     <= 1'b0;
            s1_exp     <= '0;
            s1_mx      <= '0;
            s1_my      <= '0;
            s1_byp_val <= '0;
            v2         <= 1'b0;
            s2_sign    <= 1'b0;
            s2_byp     <= 1'b0;
            s2_exp     <= '0;
            s2_sum     <= '0;
            s2_byp_val <= '0;
            out_valid  <= 1'b0;
            result     <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (advance) begin
            v1         <= in_valid;
            s1_sign    <= sx;
            s1_sub     <= sa ^ sb;
            s1_byp     <= byp_c;
            s1_exp     <= ex;
            s1_mx      <= mx;
            s1_my      <= my;
            s1_byp_val <= byp_val_c;
            v2         <= v1;
            s2_sign    <= s1_sign;
            s2_byp     <= s1_byp;
            s2_exp     <= s1_exp;
            s2_sum     <= s1_sub ? ({1'b0, s1_mx} - {1'b0, s1_my})
                                 : ({1'b0, s1_mx} + {1'b0, s1_my});
            s2_byp_val <= s1_byp_val;
            out_valid  <= v2;
            result     <= res_c;
            overflow   <= v2 & ovf_c;
            underflow  <= v2 & unf_c;
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe: directed vectors, backpressure and mid-flight reset.
module tb_fp_addsub_pipe;
    import fp_pkg::*;

    typedef struct packed {
        logic [15:0]      id;
        logic [DEF_W-1:0] res;
        logic             ovf;
        logic             unf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n, in_valid, in_ready, op_sub, out_valid, out_ready;
    logic             overflow, underflow;
    logic [DEF_W-1:0] a, b, result;

    exp_t             sb_q[$];
    exp_t             mon_e;
    int               n_tests = 0;
    int               n_fail  = 0;
    int               n_sent  = 0;
    logic             hold_pend = 1'b0;
    logic [DEF_W-1:0] hold_res;

    fp_addsub_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DEF_W-1:0] act, input logic [DEF_W-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Drive at posedge+1, accept is decided by in_ready seen at the following negedge.
    task automatic send(input logic [DEF_W-1:0] va, input logic [DEF_W-1:0] vb, input logic vs,
                        input logic [DEF_W-1:0] vr, input logic vo, input logic vu);
        int   guard = 0;
        exp_t e;
        a        = va;
        b        = vb;
        op_sub   = vs;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout vec%0d in_ready=%b required=1", n_sent, in_ready);
        end else begin
            e.id  = 16'(n_sent);
            e.res = vr;
            e.ovf = vo;
            e.unf = vu;
            sb_q.push_back(e);
        end
        n_sent++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb_q.size() != 0 && guard < 60) begin
            @(posedge clk);
            guard++;
        end
        #1;
        check("drain_remaining", DEF_W'(sb_q.size()), '0);
    endtask

    // Monitor: pops on every output transfer and checks hold stability under backpressure.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                n_tests++;
                if (!out_valid || result !== hold_res) begin
                    n_fail++;
                    $display("FAIL hold_stable valid=%b result=%h required valid=1 result=%h",
                             out_valid, result, hold_res);
                end
            end
            if (out_valid && !out_ready) begin
                n_tests++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_in_ready actual=%b required=0", in_ready);
                end
                hold_pend = 1'b1;
                hold_res  = result;
            end else begin
                hold_pend = 1'b0;
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output result=%h required=no output", result);
                end else begin
                    mon_e = sb_q.pop_front();
                    if ({result, overflow, underflow} !== {mon_e.res, mon_e.ovf, mon_e.unf}) begin
                        n_fail++;
                        $display("FAIL vec%0d result=%h ovf=%b unf=%b required result=%h ovf=%b unf=%b",
                                 mon_e.id, result, overflow, underflow, mon_e.res, mon_e.ovf, mon_e.unf);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op_sub    = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", DEF_W'(out_valid), '0);
        check("rst_result",    result,            '0);
        check("rst_overflow",  DEF_W'(overflow),  '0);
        check("rst_underflow", DEF_W'(underflow), '0);
        check("rst_in_ready",  DEF_W'(in_ready),  DEF_W'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic arithmetic, rounding and flag boundaries
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0);
        send(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0);
        send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0);
        send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
        send(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 1'b0, 1'b0);
        send(32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 1'b0, 1'b0);
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0);
        send(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 32'hFF800000, 1'b1, 1'b0);
        send(32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 1'b1, 1'b0);
        send(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b1);
        send(32'h80800001, 32'h80800000, 1'b1, 32'h80000000, 1'b0, 1'b1);
        // Zero handling and flush-to-zero
        send(32'h00000000, 32'hBF800000, 1'b0, 32'hBF800000, 1'b0, 1'b0);
        send(32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 1'b0, 1'b0);
        send(32'h007FFFFF, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
        send(32'h3F800000, 32'h00000001, 1'b1, 32'h3F800000, 1'b0, 1'b0);
        send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0);
        send(32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0);
        send(32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b0, 1'b0);
`ifdef FP_ADDSUB_SPECIAL_EN
        send(32'h7F800000, 32'h3F800000, 1'b0, inf_pat(1'b0), 1'b0, 1'b0);
        send(32'h7F800000, 32'hFF800000, 1'b0, qnan_pat(),    1'b0, 1'b0);
        send(32'h7FC00001, 32'h3F800000, 1'b0, qnan_pat(),    1'b0, 1'b0);
`else
        send(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b1, 1'b0);
        send(32'h7F800000, 32'hFF800000, 1'b0, 32'h00000000, 1'b0, 1'b0);
        send(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7F800000, 1'b1, 1'b0);
`endif
        drain();

        // Back-to-back stream with a 5-cycle consumer stall in the middle
        fork
            begin
                send(32'h40000000, 32'h40400000, 1'b0, 32'h40A00000, 1'b0, 1'b0);
                send(32'h41200000, 32'h40800000, 1'b1, 32'h40C00000, 1'b0, 1'b0);
                send(32'hBF800000, 32'h40000000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
                send(32'h3F000000, 32'h3E800000, 1'b0, 32'h3F400000, 1'b0, 1'b0);
                send(32'h42C80000, 32'hC2C80000, 1'b0, 32'h00000000, 1'b0, 1'b0);
                send(32'hC0400000, 32'h40000000, 1'b1, 32'hC0A00000, 1'b0, 1'b0);
                send(32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 1'b0, 1'b0);
                send(32'h4B800000, 32'h40400000, 1'b0, 32'h4B800002, 1'b0, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three operations in flight; only post-reset work may emerge
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0);
        send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 1'b0, 1'b0);
        send(32'h40800000, 32'h40800000, 1'b0, 32'h41000000, 1'b0, 1'b0);
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("midrst_out_valid", DEF_W'(out_valid), '0);
        check("midrst_in_ready",  DEF_W'(in_ready),  DEF_W'(1));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("postrst_idle", DEF_W'(out_valid), '0);
        send(32'h40A00000, 32'h3F800000, 1'b1, 32'h40800000, 1'b0, 1'b0);
        send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
